// File: rtl/line_mem_pkg.sv
// rtl/line_mem_pkg.sv - shared constants and state type for the line memory responder
//
// Purpose: single home for the cache-line width, the byte-offset width of a
// line address, and the responder FSM state encoding.
// Ports: none (package).

package line_mem_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;    // 32-byte line -> low 5 address bits select a byte

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - DEPTH x LINE_W line storage with synchronous write and registered read
//
// Purpose: backing array for the responder. The array itself has no reset so
// contents stay undefined until written; only the read register is reset.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset (read register only)
//   we_i     - write enable, stores wdata_i at idx_i on the clock edge
//   re_i     - read enable, loads rdata_o from idx_i on the clock edge
//   idx_i    - line index
//   wdata_i  - write data
//   rdata_o  - registered read data, holds between reads

module line_ram #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[idx_i];
    end
  end

endmodule

// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency line read/write responder behind the data cache
//
// Purpose: accepts one 256-bit line request at a time, waits LATENCY cycles,
// performs the access and completes it with a one-cycle acknowledge.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   enable_i - request valid, held by the initiator until ack_o
//   write_i  - 1 = line write, 0 = line read (sampled with enable_i)
//   addr_i   - byte address; line index = addr_i[5 +: log2(DEPTH)], other bits ignored
//   data_i   - write data (sampled with enable_i)
//   ack_o    - one-cycle completion pulse
//   data_o   - read data, valid with ack_o on a read, otherwise holds

module line_memory_responder #(
  parameter int LINE_W  = line_mem_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  import line_mem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  // Counter reaches LATENCY on the access edge, so it needs room for that value.
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              wr_q;
  logic              access;
  logic              ram_we;
  logic              ram_re;
  logic              unused_addr;

  // Offset bits and bits above the index are deliberately dropped (aliasing).
  assign unused_addr = ^addr_i;

  assign access = (state_q == BUSY) && (cnt_q == CNT_LAST);
  // A reset landing on the access edge cancels the access.
  assign ram_we = access && wr_q  && !rst_i;
  assign ram_re = access && !wr_q && !rst_i;
  assign ack_o  = (state_q == ACK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = BUSY;
      BUSY:    if (access)   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured once at acceptance; inputs during BUSY/ACK are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (state_q == IDLE && enable_i) begin
      cnt_q   <= '0;
      idx_q   <= addr_i[OFFSET_BITS +: IDX_W];
      wdata_q <= data_i;
      wr_q    <= write_i;
    end else if (state_q == BUSY) begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  line_ram #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - directed self-checking bench for line_memory_responder

module tb_line_memory_responder;

  localparam int LATENCY = 10;
  localparam int TMO     = 40;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_5A = {32{8'h5A}};
  localparam logic [255:0] PAT_C3 = {32{8'hC3}};
  localparam logic [255:0] PAT_D4 = {8{32'hDEAD_0004}};
  localparam logic [255:0] PAT_D5 = {8{32'hBEEF_0005}};

  line_memory_responder #(
    .LINE_W  (256),
    .DEPTH   (512),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Counts negedges without ack until ack is seen (bounded); ends on the ack negedge.
  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk_i);
      if (ack_o) break;
      n++;
    end
  endtask

  // Starts at a negedge, runs one full request, ends at the negedge after ACK.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] a,
                        input logic [255:0] d, input bit scramble,
                        output logic [255:0] rd);
    int n;
    enable_i = 1'b1; write_i = wr; addr_i = a; data_i = d;
    @(posedge clk_i);
    n = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk_i);
      if (ack_o) break;
      n++;
      if (scramble) begin
        addr_i  = $urandom;
        data_i  = {8{$urandom}};
        write_i = 1'($urandom);
      end
    end
    check({tag, "_latency"}, 256'(n), 256'(LATENCY));
    rd = data_o;
    enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
    @(negedge clk_i);
    check({tag, "_ack_single"}, 256'(ack_o), 256'd0);
  endtask

  initial begin
    logic [255:0] rd;
    int n;
    int acks;

    // Reset held with a pending-looking request: nothing must be accepted.
    rst_i = 1'b1; enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h40; data_i = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_ack", 256'(ack_o), 256'd0);
      check("rst_data", data_o, 256'd0);
    end
    rst_i = 1'b0; enable_i = 1'b0;
    acks = 0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    check("rst_no_accept", 256'(acks), 256'd0);

    // Write then read line 2; data_o must not move on the write.
    do_req("wr40", 1'b1, 32'h0000_0040, PAT_A5, 1'b0, rd);
    check("wr40_data_hold", rd, 256'd0);
    do_req("rd40", 1'b0, 32'h0000_0040, '0, 1'b0, rd);
    check("rd40_data", rd, PAT_A5);
    do_req("wr20", 1'b1, 32'h0000_0020, PAT_5A, 1'b0, rd);
    check("wr20_data_hold", rd, PAT_A5);

    // Offset bits and upper bits alias onto the same line.
    do_req("rd47", 1'b0, 32'h0000_0047, '0, 1'b0, rd);
    check("rd47_data", rd, PAT_A5);
    do_req("rd4040", 1'b0, 32'h0000_4040, '0, 1'b0, rd);
    check("rd4040_data", rd, PAT_A5);
    do_req("rd20", 1'b0, 32'h0000_0020, '0, 1'b0, rd);
    check("rd20_data", rd, PAT_5A);

    // Inputs churn every BUSY cycle; the latched request must win.
    do_req("wr60s", 1'b1, 32'h0000_0060, PAT_C3, 1'b1, rd);
    do_req("rd60", 1'b0, 32'h0000_0060, '0, 1'b0, rd);
    check("rd60_data", rd, PAT_C3);
    do_req("rd40b", 1'b0, 32'h0000_0040, '0, 1'b0, rd);
    check("rd40b_data", rd, PAT_A5);
    do_req("rd20s", 1'b0, 32'h0000_0020, '0, 1'b1, rd);
    check("rd20s_data", rd, PAT_5A);

    // Reset 4 cycles into a write of line 3: no ack, no write, data_o cleared.
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0060; data_i = 256'h1;
    @(posedge clk_i);
    for (int i = 0; i < 4; i++) @(negedge clk_i);
    rst_i = 1'b1; enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_ack", 256'(ack_o), 256'd0);
    check("midrst_data", data_o, 256'd0);
    acks = 0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    check("midrst_no_ack", 256'(acks), 256'd0);
    do_req("rd60r", 1'b0, 32'h0000_0060, '0, 1'b0, rd);
    check("rd60r_data", rd, PAT_C3);

    // Back-to-back: enable held across ack, alternating write/read/write.
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0080; data_i = PAT_D4;
    @(posedge clk_i);
    wait_ack(n);
    check("b2b_first_latency", 256'(n), 256'(LATENCY));
    write_i = 1'b0;
    wait_ack(n);
    check("b2b_gap_rd", 256'(n), 256'(LATENCY + 1));
    check("b2b_rd_data", data_o, PAT_D4);
    write_i = 1'b1; addr_i = 32'h0000_00A0; data_i = PAT_D5;
    wait_ack(n);
    check("b2b_gap_wr", 256'(n), 256'(LATENCY + 1));
    check("b2b_wr_data_hold", data_o, PAT_D4);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("b2b_ack_single", 256'(ack_o), 256'd0);
    do_req("rdA0", 1'b0, 32'h0000_00A0, '0, 1'b0, rd);
    check("rdA0_data", rd, PAT_D5);

    // Idle cycles leave data_o alone.
    for (int i = 0; i < 5; i++) @(negedge clk_i);
    check("idle_data_hold", data_o, PAT_D5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
